// File: rtl/mem_stage.sv
// MEM pipeline stage: bus master FSM for LDW/STW plus the MEM/WB pipeline register.
// Optional MEM_BUS_TIMEOUT_EN abandons a bus access stuck for 255 cycles and reports BUS_ERR.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   output logic        busy,
   input  logic [29:0] ex_pc,
   input  logic        ex_en,
   input  logic        ex_br_flag,
   input  logic [1:0]  ex_mem_op,
   input  logic [31:0] ex_mem_wr_data,
   input  logic [1:0]  ex_ctrl_op,
   input  logic [4:0]  ex_dst_addr,
   input  logic        ex_gpr_we_,
   input  logic [2:0]  ex_exp_code,
   input  logic [31:0] ex_out,
   output logic        bus_req_,
   input  logic        bus_grnt_,
   output logic        bus_as_,
   output logic        bus_rw,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_wr_data,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy_,
   output logic [29:0] mem_pc,
   output logic        mem_en,
   output logic        mem_br_flag,
   output logic [1:0]  mem_ctrl_op,
   output logic [4:0]  mem_dst_addr,
   output logic        mem_gpr_we_,
   output logic [2:0]  mem_exp_code,
   output logic [31:0] mem_out
);

   localparam logic [1:0] MEM_OP_NOP     = 2'h0;
   localparam logic [1:0] MEM_OP_LDW     = 2'h1;
   localparam logic [1:0] MEM_OP_STW     = 2'h2;
   localparam logic [1:0] CTRL_OP_NOP    = 2'h0;
   localparam logic [2:0] EXP_NO_EXP     = 3'h0;
   localparam logic [2:0] EXP_MISS_ALIGN = 3'h4;
   localparam logic [2:0] EXP_BUS_ERR    = 3'h7;
   localparam logic       DISABLE_       = 1'b1;
   localparam logic       READ           = 1'b1;
   localparam logic       WRITE          = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACCESS
   } state_t;

   state_t state;
   logic   miss_align;
   logic   pending;
   logic   timeout;

   assign miss_align = (ex_mem_op != MEM_OP_NOP) && (ex_out[1:0] != 2'b00);
   assign pending    = ex_en && (ex_mem_op != MEM_OP_NOP) &&
                       (ex_exp_code == EXP_NO_EXP) && (ex_out[1:0] == 2'b00);

`ifdef MEM_BUS_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (state == ST_IDLE) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   assign timeout = (state != ST_IDLE) && (tmo_cnt == 8'hFF);
`else
   assign timeout = 1'b0;
`endif

   // Request/busy must react in the same cycle the access appears, so they stay combinational.
   always_comb begin
      busy     = 1'b0;
      bus_req_ = 1'b1;
      if (reset && !timeout) begin
         case (state)
            ST_IDLE: begin
               busy     = pending;
               bus_req_ = !pending;
            end
            ST_REQ: begin
               busy     = 1'b1;
               bus_req_ = 1'b0;
            end
            ST_ACCESS: begin
               busy     = bus_rdy_;
               bus_req_ = 1'b0;
            end
            default: begin
               busy     = 1'b0;
               bus_req_ = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         bus_as_     <= 1'b1;
         bus_rw      <= READ;
         bus_addr    <= '0;
         bus_wr_data <= '0;
      end else begin
         bus_as_ <= 1'b1;
         if (timeout) begin
            state       <= ST_IDLE;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (pending) state <= ST_REQ;
               end
               ST_REQ: begin
                  if (!bus_grnt_) begin
                     state       <= ST_ACCESS;
                     bus_as_     <= 1'b0;
                     bus_rw      <= (ex_mem_op == MEM_OP_STW) ? WRITE : READ;
                     bus_addr    <= ex_out[31:2];
                     bus_wr_data <= ex_mem_wr_data;
                  end
               end
               ST_ACCESS: begin
                  if (!bus_rdy_) begin
                     state       <= ST_IDLE;
                     bus_rw      <= READ;
                     bus_addr    <= '0;
                     bus_wr_data <= '0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_pc       <= '0;
         mem_en       <= 1'b0;
         mem_br_flag  <= 1'b0;
         mem_ctrl_op  <= CTRL_OP_NOP;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= DISABLE_;
         mem_exp_code <= EXP_NO_EXP;
         mem_out      <= '0;
      end else if (!stall) begin
         if (flush) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= DISABLE_;
            mem_exp_code <= EXP_NO_EXP;
            mem_out      <= '0;
         end else begin
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_dst_addr <= ex_dst_addr;
            if (ex_exp_code != EXP_NO_EXP) begin
               mem_exp_code <= ex_exp_code;
               mem_gpr_we_  <= ex_gpr_we_;
               mem_out      <= ex_out;
            end else if (miss_align) begin
               mem_exp_code <= EXP_MISS_ALIGN;
               mem_gpr_we_  <= DISABLE_;
               mem_out      <= '0;
            end else if (timeout) begin
               mem_exp_code <= EXP_BUS_ERR;
               mem_gpr_we_  <= DISABLE_;
               mem_out      <= '0;
            end else begin
               // The pipeline is held by busy until the ready cycle, so the last capture holds the load data.
               mem_exp_code <= EXP_NO_EXP;
               mem_gpr_we_  <= ex_gpr_we_;
               mem_out      <= (pending && ex_mem_op == MEM_OP_LDW) ? bus_rd_data : ex_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: bus handshake, MEM/WB register, reset and timeout.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        busy;
   logic [29:0] ex_pc;
   logic        ex_en;
   logic        ex_br_flag;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [1:0]  ex_ctrl_op;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;
   logic [31:0] ex_out;
   logic        bus_req_;
   logic        bus_grnt_;
   logic        bus_as_;
   logic        bus_rw;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_;
   logic [29:0] mem_pc;
   logic        mem_en;
   logic        mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic        mem_gpr_we_;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   int n_tests;
   int n_fail;

   mem_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
      .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
      .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
      .bus_rdy_(bus_rdy_), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
      .mem_exp_code(mem_exp_code), .mem_out(mem_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      stall = 1'b0; flush = 1'b0;
      ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_mem_op = 2'h0;
      ex_mem_wr_data = '0; ex_ctrl_op = 2'h0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1;
      ex_exp_code = 3'h0; ex_out = '0;
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      idle_inputs();
      #22;
      n_tests++; if ({bus_req_, bus_as_, bus_rw} !== 3'b111) begin n_fail++;
         $display("FAIL reset_bus_ctrl: got %b expected 111", {bus_req_, bus_as_, bus_rw}); end
      n_tests++; if ({bus_addr, bus_wr_data} !== 62'h0) begin n_fail++;
         $display("FAIL reset_bus_data: got %h expected 0", {bus_addr, bus_wr_data}); end
      n_tests++; if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr} !== 40'h0) begin n_fail++;
         $display("FAIL reset_mem_ctrl: got %h expected 0", {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr}); end
      n_tests++; if ({mem_gpr_we_, mem_exp_code, mem_out} !== {1'b1, 3'h0, 32'h0}) begin n_fail++;
         $display("FAIL reset_mem_data: got %h expected %h", {mem_gpr_we_, mem_exp_code, mem_out}, {1'b1, 3'h0, 32'h0}); end
      n_tests++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_load;
      ex_en = 1'b1; ex_mem_op = 2'h1; ex_out = 32'h0000_0100; ex_gpr_we_ = 1'b0;
      ex_dst_addr = 5'd5; ex_pc = 30'h10;
      bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
      #1;
      n_tests++; if ({busy, bus_req_} !== 2'b10) begin n_fail++;
         $display("FAIL load_c0_busy_req: got %b expected 10", {busy, bus_req_}); end
      tick();
      n_tests++; if ({busy, bus_req_, bus_as_} !== 3'b101) begin n_fail++;
         $display("FAIL load_req_state: got %b expected 101", {busy, bus_req_, bus_as_}); end
      tick();
      n_tests++; if ({busy, bus_req_, bus_as_, bus_rw} !== 4'b0001) begin n_fail++;
         $display("FAIL load_access_ctrl: got %b expected 0001", {busy, bus_req_, bus_as_, bus_rw}); end
      n_tests++; if (bus_addr !== 30'h40) begin n_fail++;
         $display("FAIL load_bus_addr: got %h expected 00000040", bus_addr); end
      tick();
      n_tests++; if (mem_out !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL load_mem_out: got %h expected deadbeef", mem_out); end
      n_tests++; if ({mem_exp_code, mem_gpr_we_, mem_dst_addr, mem_en} !== {3'h0, 1'b0, 5'd5, 1'b1}) begin n_fail++;
         $display("FAIL load_mem_ctrl: got %h expected %h", {mem_exp_code, mem_gpr_we_, mem_dst_addr, mem_en}, {3'h0, 1'b0, 5'd5, 1'b1}); end
      idle_inputs();
      #1;
      n_tests++; if ({busy, bus_req_, bus_as_} !== 3'b011) begin n_fail++;
         $display("FAIL load_done_idle: got %b expected 011", {busy, bus_req_, bus_as_}); end
   endtask

   task automatic test_store;
      tick();
      ex_en = 1'b1; ex_mem_op = 2'h2; ex_out = 32'h0000_0204; ex_mem_wr_data = 32'h1234_5678;
      ex_gpr_we_ = 1'b1; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
      #1;
      n_tests++; if (busy !== 1'b1) begin n_fail++;
         $display("FAIL store_c0_busy: got %b expected 1", busy); end
      tick();
      tick();
      n_tests++; if ({bus_rw, bus_addr} !== {1'b0, 30'h81}) begin n_fail++;
         $display("FAIL store_rw_addr: got %h expected %h", {bus_rw, bus_addr}, {1'b0, 30'h81}); end
      for (int unsigned i = 0; i < 3; i++) begin
         n_tests++; if ({busy, bus_req_, bus_as_} !== {1'b1, 1'b0, (i != 0)}) begin n_fail++;
            $display("FAIL store_wait_ctrl[%0d]: got %b expected %b", i, {busy, bus_req_, bus_as_}, {1'b1, 1'b0, (i != 0)}); end
         n_tests++; if (bus_wr_data !== 32'h1234_5678) begin n_fail++;
            $display("FAIL store_wr_data[%0d]: got %h expected 12345678", i, bus_wr_data); end
         tick();
      end
      bus_rdy_ = 1'b0;
      #1;
      n_tests++; if ({busy, bus_rw} !== 2'b00) begin n_fail++;
         $display("FAIL store_rdy_cycle: got %b expected 00", {busy, bus_rw}); end
      tick();
      n_tests++; if ({mem_out, mem_gpr_we_, mem_exp_code} !== {32'h0000_0204, 1'b1, 3'h0}) begin n_fail++;
         $display("FAIL store_mem_out: got %h expected %h", {mem_out, mem_gpr_we_, mem_exp_code}, {32'h0000_0204, 1'b1, 3'h0}); end
      idle_inputs();
   endtask

   task automatic test_stall;
      stall = 1'b1; ex_en = 1'b1; ex_out = 32'h77;
      tick();
      n_tests++; if (mem_out !== 32'h0000_0204) begin n_fail++;
         $display("FAIL stall_hold: got %h expected 00000204", mem_out); end
      stall = 1'b0;
      tick();
      n_tests++; if (mem_out !== 32'h77) begin n_fail++;
         $display("FAIL stall_release: got %h expected 00000077", mem_out); end
      idle_inputs();
   endtask

   task automatic test_misalign;
      ex_en = 1'b1; ex_mem_op = 2'h1; ex_out = 32'h0000_0102; ex_gpr_we_ = 1'b0;
      #1;
      n_tests++; if ({busy, bus_req_} !== 2'b01) begin n_fail++;
         $display("FAIL misalign_no_req: got %b expected 01", {busy, bus_req_}); end
      tick();
      n_tests++; if ({mem_exp_code, mem_gpr_we_, mem_out} !== {3'h4, 1'b1, 32'h0}) begin n_fail++;
         $display("FAIL misalign_mem: got %h expected %h", {mem_exp_code, mem_gpr_we_, mem_out}, {3'h4, 1'b1, 32'h0}); end
      n_tests++; if ({bus_req_, bus_as_} !== 2'b11) begin n_fail++;
         $display("FAIL misalign_bus_idle: got %b expected 11", {bus_req_, bus_as_}); end
      idle_inputs();
   endtask

   task automatic test_passthrough;
      ex_en = 1'b1; ex_exp_code = 3'h3; ex_out = 32'h55; ex_gpr_we_ = 1'b0; ex_ctrl_op = 2'h2; ex_br_flag = 1'b1;
      tick();
      n_tests++; if ({mem_exp_code, mem_out, mem_ctrl_op, mem_br_flag} !== {3'h3, 32'h55, 2'h2, 1'b1}) begin n_fail++;
         $display("FAIL exp_passthrough: got %h expected %h", {mem_exp_code, mem_out, mem_ctrl_op, mem_br_flag}, {3'h3, 32'h55, 2'h2, 1'b1}); end
      idle_inputs();
   endtask

   task automatic test_flush;
      ex_en = 1'b1; ex_out = 32'hAA; ex_pc = 30'h123; ex_gpr_we_ = 1'b0;
      tick();
      n_tests++; if ({mem_en, mem_out, mem_pc} !== {1'b1, 32'hAA, 30'h123}) begin n_fail++;
         $display("FAIL flush_setup: got %h expected %h", {mem_en, mem_out, mem_pc}, {1'b1, 32'hAA, 30'h123}); end
      stall = 1'b1; flush = 1'b1;
      tick();
      n_tests++; if ({mem_en, mem_out} !== {1'b1, 32'hAA}) begin n_fail++;
         $display("FAIL flush_stalled_hold: got %h expected %h", {mem_en, mem_out}, {1'b1, 32'hAA}); end
      stall = 1'b0;
      tick();
      n_tests++; if ({mem_en, mem_exp_code, mem_out, mem_gpr_we_, mem_pc} !== {1'b0, 3'h0, 32'h0, 1'b1, 30'h0}) begin n_fail++;
         $display("FAIL flush_clear: got %h expected %h", {mem_en, mem_exp_code, mem_out, mem_gpr_we_, mem_pc}, {1'b0, 3'h0, 32'h0, 1'b1, 30'h0}); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_access;
      ex_en = 1'b1; ex_mem_op = 2'h1; ex_out = 32'h0000_0300; ex_gpr_we_ = 1'b0;
      bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
      tick();
      tick();
      n_tests++; if ({bus_req_, bus_as_, bus_addr} !== {1'b0, 1'b0, 30'hC0}) begin n_fail++;
         $display("FAIL rst_mid_access_setup: got %h expected %h", {bus_req_, bus_as_, bus_addr}, {1'b0, 1'b0, 30'hC0}); end
      #2 reset = 1'b0;
      #1;
      n_tests++; if ({bus_req_, bus_as_, busy} !== 3'b110) begin n_fail++;
         $display("FAIL rst_async_bus: got %b expected 110", {bus_req_, bus_as_, busy}); end
      n_tests++; if ({bus_addr, bus_rw, mem_out} !== {30'h0, 1'b1, 32'h0}) begin n_fail++;
         $display("FAIL rst_async_data: got %h expected %h", {bus_addr, bus_rw, mem_out}, {30'h0, 1'b1, 32'h0}); end
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      n_tests++; if ({bus_req_, bus_as_, busy, mem_exp_code} !== {3'b110, 3'h0}) begin n_fail++;
         $display("FAIL rst_release_idle: got %b expected 110000", {bus_req_, bus_as_, busy, mem_exp_code}); end
      ex_en = 1'b1; ex_mem_op = 2'h1; ex_out = 32'h0000_0010; ex_gpr_we_ = 1'b0;
      bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D;
      tick();
      tick();
      n_tests++; if ({bus_as_, bus_addr} !== {1'b0, 30'h4}) begin n_fail++;
         $display("FAIL rst_post_access: got %h expected %h", {bus_as_, bus_addr}, {1'b0, 30'h4}); end
      tick();
      n_tests++; if (mem_out !== 32'hCAFE_F00D) begin n_fail++;
         $display("FAIL rst_post_load: got %h expected cafef00d", mem_out); end
      idle_inputs();
   endtask

   task automatic test_grant_wait;
      int cyc;
      cyc = 0;
      ex_en = 1'b1; ex_mem_op = 2'h1; ex_out = 32'h0000_0100; ex_gpr_we_ = 1'b0;
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD_F00D;
      #1;
`ifdef MEM_BUS_TIMEOUT_EN
      while (busy === 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
      n_tests++; if (cyc != 256) begin n_fail++;
         $display("FAIL timeout_cycles: got %0d expected 256", cyc); end
      n_tests++; if ({busy, bus_req_} !== 2'b01) begin n_fail++;
         $display("FAIL timeout_release: got %b expected 01", {busy, bus_req_}); end
      tick();
      n_tests++; if ({mem_exp_code, mem_gpr_we_} !== {3'h7, 1'b1}) begin n_fail++;
         $display("FAIL timeout_bus_err: got %h expected %h", {mem_exp_code, mem_gpr_we_}, {3'h7, 1'b1}); end
`else
      for (int unsigned i = 0; i < 40; i++) begin
         tick();
         if (busy === 1'b1 && bus_req_ === 1'b0) cyc++;
      end
      n_tests++; if (cyc != 40) begin n_fail++;
         $display("FAIL grant_wait_busy: got %0d expected 40", cyc); end
      bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
      tick();
      n_tests++; if ({busy, bus_as_} !== 2'b00) begin n_fail++;
         $display("FAIL grant_wait_access: got %b expected 00", {busy, bus_as_}); end
      tick();
      n_tests++; if ({mem_out, mem_exp_code} !== {32'h0BAD_F00D, 3'h0}) begin n_fail++;
         $display("FAIL grant_wait_load: got %h expected %h", {mem_out, mem_exp_code}, {32'h0BAD_F00D, 3'h0}); end
`endif
      idle_inputs();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_load();
      test_store();
      test_stall();
      test_misalign();
      test_passthrough();
      test_flush();
      test_reset_mid_access();
      test_grant_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide `clk  in  1` as the single clock; all state updates on rising edge.
REQ-002 SHALL provide `reset  in  1` as the reset: asynchronous, active-low (`RESET_EDGE` negedge, `RESET_ENABLE` = 0).
REQ-003 SHALL provide these pipeline-control ports:
- `stall  in  1`: hold MEM/WB register.
- `flush  in  1`: clear MEM/WB register.
- `busy  out  1`: memory access in progress, stall request.
REQ-004 SHALL accept these EX/MEM inputs:
- `ex_pc  in  30`
- `ex_en  in  1`
- `ex_br_flag  in  1`
- `ex_mem_op  in  2`: NOP / LDW / STW.
- `ex_mem_wr_data  in  32`
- `ex_ctrl_op  in  2`
- `ex_dst_addr  in  5`
- `ex_gpr_we_  in  1`: active-low.
- `ex_exp_code  in  3`
- `ex_out  in  32`: ALU result, byte address for LDW/STW.
REQ-005 SHALL provide these bus master ports:
- `bus_req_  out  1`
- `bus_grnt_  in  1`
- `bus_as_  out  1`
- `bus_rw  out  1`: READ = 1, WRITE = 0.
- `bus_addr  out  30`
- `bus_wr_data  out  32`
- `bus_rd_data  in  32`
- `bus_rdy_  in  1`
All control signals are active-low except `bus_rw`.
REQ-006 SHALL provide these MEM/WB outputs:
- `mem_pc  out  30`
- `mem_en  out  1`
- `mem_br_flag  out  1`
- `mem_ctrl_op  out  2`
- `mem_dst_addr  out  5`
- `mem_gpr_we_  out  1`
- `mem_exp_code  out  3`
- `mem_out  out  32`

Function
REQ-007 SHALL define access pending as all of:
- `ex_en` = 1
- `ex_mem_op` != NOP
- `ex_exp_code` = NO_EXP
- `ex_out[1:0]` = 2'b00
REQ-008 SHALL detect misalignment: `ex_mem_op` != NOP and `ex_out[1:0]` != 0. A misaligned op SHALL make no bus access and SHALL register `mem_exp_code` = MISS_ALIGN, `mem_gpr_we_` = DISABLE_, `mem_out` = 0.
REQ-009 SHALL implement FSM states IDLE, REQ, ACCESS.
- IDLE -> REQ when access pending.
- REQ -> ACCESS when `bus_grnt_` = 0.
- ACCESS -> IDLE when `bus_rdy_` = 0.
REQ-010 SHALL drive `bus_req_` = 0 in the IDLE-with-access-pending cycle, in REQ, and in ACCESS; `bus_req_` = 1 otherwise.
REQ-011 SHALL drive `bus_as_` = 0 only in the first cycle of ACCESS. In all ACCESS cycles it SHALL drive `bus_addr` = `ex_out[31:2]`, `bus_rw` per op, and `bus_wr_data` = `ex_mem_wr_data`.
REQ-012 SHALL drive `busy` combinationally = 1 in these cases, and 0 otherwise:
- IDLE with access pending.
- REQ.
- ACCESS with `bus_rdy_` = 1.
REQ-013 SHALL set `mem_out` = `bus_rd_data` for LDW, captured in the `bus_rdy_` = 0 cycle. For STW and NOP it SHALL set `mem_out` = `ex_out`.
REQ-014 SHALL update the MEM/WB register on a clock edge only when `stall` = 0.
- Flush clears it to reset values.
- Otherwise it captures the EX inputs per REQ-008/REQ-013.
- Non-NO_EXP `ex_exp_code` passes through unchanged.
REQ-015 SHALL have the FSM ignore `stall`/`flush` once in REQ or ACCESS; the access runs to completion.
REQ-016 SHALL have a load/store latency of min 2 cycles after `busy` rises (grant and ready both immediate).

Reset
REQ-017 SHALL, on `reset` = 0, immediately force the following regardless of FSM state (mid-access included):
- FSM = IDLE
- `bus_req_` = `bus_as_` = 1, `bus_rw` = READ, `bus_addr` = 0, `bus_wr_data` = 0
- `mem_pc` = 0, `mem_en` = 0, `mem_br_flag` = 0
- `mem_ctrl_op` = CTRL_OP_NOP, `mem_dst_addr` = 0, `mem_gpr_we_` = DISABLE_
- `mem_exp_code` = NO_EXP, `mem_out` = 0

Configuration
REQ-018 SHALL, with `MEM_BUS_TIMEOUT_EN` defined, add an 8-bit counter that clears on entering REQ and increments each REQ/ACCESS cycle.
- At count 255: abandon the access (FSM -> IDLE, bus released), `busy` = 0 that cycle.
- Register `mem_exp_code` = BUS_ERR (3'h7), `mem_gpr_we_` = DISABLE_.
REQ-019 SHALL, without `MEM_BUS_TIMEOUT_EN`, omit the counter and wait on `bus_grnt_`/`bus_rdy_` indefinitely.

Verification
REQ-020 Aligned LDW at `ex_out` = 0x0000_0100, grant and ready immediate, `bus_rd_data` = 0xDEAD_BEEF -> `bus_addr` = 0x40, `busy` high 2 cycles, then `mem_out` = 0xDEADBEEF.
REQ-021 STW at 0x0000_0204 with data 0x1234_5678, ready delayed 3 cycles -> `bus_rw` = 0, `bus_wr_data` held, `busy` = 1 until ready, `mem_out` = 0x00000204.
REQ-022 LDW at 0x0000_0102 -> no `bus_req_`, `mem_exp_code` = MISS_ALIGN, `mem_gpr_we_` = 1.
REQ-023 Reset asserted in ACCESS -> `bus_req_`/`bus_as_` = 1 asynchronously; after release FSM = IDLE with outputs at reset values.
REQ-024 Flush with `stall` = 0 and non-memory op -> next cycle `mem_en` = 0, `mem_exp_code` = NO_EXP, `mem_out` = 0.
REQ-025 With `MEM_BUS_TIMEOUT_EN` defined and grant never given -> after 255 cycles `busy` = 0, `bus_req_` = 1, `mem_exp_code` = 3'h7.
